core_icache: RTL and testbench

- Direct-mapped instruction cache sitting directly upstream of the fetch stage.
- Serves halfword-aligned 32-bit fetch windows to the fetch stage.
- Refills 64-byte lines from the memory bus in eight 64-bit beats.
- Hit data is combinational from the fetch address register, so the fetch stage sees zero-latency hits. Misses stall fetch by holding o_data_ready low until the refill completes.

---
 rtl/core_icache.sv | 145 ++++++++++++++
 tb/tb_core_icache.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/core_icache.sv
// Direct-mapped instruction cache: 64-byte lines, 8x64-bit refill bursts, zero-latency hits.
// Optional hit/miss statistics counters are built when ICACHE_STATS_EN is defined.
module core_icache #(
   parameter int NUM_LINES = 64,
   parameter int ADDR_W    = 64
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_fetch_en,
   output logic [31:0]       o_data,
   output logic              o_data_ready,
   input  logic              i_flush,
   output logic              o_mem_req,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic              i_mem_ack,
   input  logic [63:0]       i_mem_data,
   output logic              o_busy,
   output logic [31:0]       o_hit_count,
   output logic [31:0]       o_miss_count
);

   // state | meaning
   // IDLE  | serving hits from the array, looking for a miss
   // FILL  | refill burst in flight for the line latched in o_mem_addr
   typedef enum logic {IDLE, FILL} state_t;

   localparam int IDX_W = $clog2(NUM_LINES);
   localparam int TAG_W = ADDR_W - 6 - IDX_W;

   state_t               state;
   logic [2:0]           beat;
   logic                 flushed;
   logic [NUM_LINES-1:0] valid;

   logic [511:0]         data_mem [NUM_LINES];
   logic [TAG_W-1:0]     tag_mem  [NUM_LINES];

   logic [IDX_W-1:0]     idx;
   logic [TAG_W-1:0]     tag;
   logic [IDX_W-1:0]     fill_idx;
   logic [TAG_W-1:0]     fill_tag;
   logic [511:0]         line_rd;
   logic [8:0]           shamt;
   logic                 hit;
   logic                 fill_start;
   logic                 beat_wr;
   logic                 last_beat;
   logic                 unused;

   assign idx      = i_addr[6 +: IDX_W];
   assign tag      = i_addr[ADDR_W-1 -: TAG_W];
   assign fill_idx = o_mem_addr[6 +: IDX_W];
   assign fill_tag = o_mem_addr[ADDR_W-1 -: TAG_W];
   assign unused   = i_addr[0];

   assign hit = valid[idx] && (tag_mem[idx] == tag);

   // Shifting the whole line right leaves zeros above halfword 31 for the last window.
   assign line_rd = data_mem[idx];
   assign shamt   = {i_addr[5:1], 4'b0000};
   assign o_data  = 32'(line_rd >> shamt);

   assign o_data_ready = hit && i_fetch_en && (state == IDLE);
   assign o_busy       = (state == FILL);

   assign fill_start = (state == IDLE) && i_fetch_en && !hit && !i_flush;
   assign beat_wr    = (state == FILL) && i_mem_ack;
   assign last_beat  = beat_wr && (beat == 3'd7);

   // Storage arrays carry no reset; the valid vector alone decides hits.
   always_ff @(posedge i_clk) begin
      if (beat_wr)
         data_mem[fill_idx][{beat, 6'b000000} +: 64] <= i_mem_data;
      if (last_beat)
         tag_mem[fill_idx] <= fill_tag;
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= IDLE;
         beat       <= 3'd0;
         flushed    <= 1'b0;
         valid      <= '0;
         o_mem_req  <= 1'b0;
         o_mem_addr <= '0;
      end else begin
         if (i_flush)
            valid <= '0;
         else if (last_beat && !flushed)
            valid[fill_idx] <= 1'b1;

         case (state)
            IDLE: begin
               if (fill_start) begin
                  state      <= FILL;
                  o_mem_addr <= {i_addr[ADDR_W-1:6], 6'b000000};
                  o_mem_req  <= 1'b1;
                  beat       <= 3'd0;
                  flushed    <= 1'b0;
               end
            end
            FILL: begin
               if (i_flush)
                  flushed <= 1'b1;
               if (i_mem_ack) begin
                  beat <= beat + 3'd1;
                  if (beat == 3'd7) begin
                     state     <= IDLE;
                     o_mem_req <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else if (i_flush) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (o_data_ready)
            hit_count <= hit_count + 32'd1;
         if (fill_start)
            miss_count <= miss_count + 32'd1;
      end
   end

   assign o_hit_count  = hit_count;
   assign o_miss_count = miss_count;
`else
   assign o_hit_count  = 32'd0;
   assign o_miss_count = 32'd0;
`endif

endmodule

// File: tb/tb_core_icache.sv
// Directed self-checking bench for core_icache (default parameters).
module tb_core_icache;

   logic        i_clk;
   logic        i_reset_n;
   logic [63:0] i_addr;
   logic        i_fetch_en;
   logic [31:0] o_data;
   logic        o_data_ready;
   logic        i_flush;
   logic        o_mem_req;
   logic [63:0] o_mem_addr;
   logic        i_mem_ack;
   logic [63:0] i_mem_data;
   logic        o_busy;
   logic [31:0] o_hit_count;
   logic [31:0] o_miss_count;

   int n_checks = 0;
   int n_errors = 0;

   core_icache dut (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_addr       (i_addr),
      .i_fetch_en   (i_fetch_en),
      .o_data       (o_data),
      .o_data_ready (o_data_ready),
      .i_flush      (i_flush),
      .o_mem_req    (o_mem_req),
      .o_mem_addr   (o_mem_addr),
      .i_mem_ack    (i_mem_ack),
      .i_mem_data   (i_mem_data),
      .o_busy       (o_busy),
      .o_hit_count  (o_hit_count),
      .o_miss_count (o_miss_count)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #2;
   endtask

   function automatic logic [63:0] beat_data(input int k);
      return 64'h0706050403020100 + 64'(k) * 64'h0808080808080808;
   endfunction

   // Entered right after the edge that moved the cache into FILL; leaves it one cycle after the 8th ack.
   task automatic burst(input logic [63:0] exp_addr, input int flush_at,
                        input int redir_at, input logic [63:0] redir_addr);
      chk("req_on", o_mem_req, 1);
      chk("busy_on", o_busy, 1);
      chk("mem_addr", o_mem_addr, exp_addr);
      for (int k = 0; k < 8; k++) begin
         i_mem_ack  = 1'b1;
         i_mem_data = beat_data(k);
         i_flush    = (k == flush_at);
         if (k == redir_at) i_addr = redir_addr;
         #1;
         chk("req_hold", o_mem_req, 1);
         chk("no_rdy_fill", o_data_ready, 0);
         tick();
      end
      i_mem_ack = 1'b0;
      i_flush   = 1'b0;
      #1;
      chk("req_drop", o_mem_req, 0);
      chk("busy_drop", o_busy, 0);
   endtask

   initial begin
      i_reset_n  = 1'b0;
      i_addr     = '0;
      i_fetch_en = 1'b0;
      i_flush    = 1'b0;
      i_mem_ack  = 1'b0;
      i_mem_data = '0;
      tick();
      tick();
      chk("rst_req", o_mem_req, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_addr", o_mem_addr, 0);
      chk("rst_rdy", o_data_ready, 0);
      chk("rst_hits", o_hit_count, 0);
      chk("rst_miss", o_miss_count, 0);
      i_reset_n = 1'b1;
      tick();

      // Cold miss with exact cycle latency
      i_addr = 64'h1000; i_fetch_en = 1'b1;
      #1 chk("cold_rdy0", o_data_ready, 0);
      tick();
      burst(64'h1000, -1, -1, 0);
      chk("cold_rdy9", o_data_ready, 1);
      chk("cold_data", o_data, 32'h03020100);

      // Windows within the filled line
      i_addr = 64'h1002;
      #1 chk("win_1002_rdy", o_data_ready, 1);
      chk("win_1002", o_data, 32'h05040302);
      i_addr = 64'h101E;
      #1 chk("win_101e", o_data, 32'h21201F1E);
      i_addr = 64'h103E;
      #1 chk("win_103e_rdy", o_data_ready, 1);
      chk("win_103e", o_data, 32'h00003F3E);
      i_fetch_en = 1'b0;
      #1 chk("no_en_rdy", o_data_ready, 0);

      // Aliasing: 0x2000 shares index 0 with 0x1000
      i_addr = 64'h2000; i_fetch_en = 1'b1;
      #1 chk("alias_miss", o_data_ready, 0);
      tick();
      burst(64'h2000, -1, -1, 0);
      chk("alias_hit", o_data_ready, 1);
      i_addr = 64'h1000;
      #1 chk("alias_evict", o_data_ready, 0);
      tick();
      burst(64'h1000, -1, -1, 0);
      chk("refill_hit", o_data_ready, 1);

      // Redirect mid-refill
      i_fetch_en = 1'b0; i_flush = 1'b1;
      tick();
      i_flush = 1'b0; i_fetch_en = 1'b1;
      #1 chk("flush_idle", o_data_ready, 0);
      tick();
      burst(64'h1000, -1, 3, 64'h3000);
      chk("redir_miss", o_data_ready, 0);
      i_addr = 64'h1000;
      #1 chk("redir_old_line", o_data_ready, 1);
      i_addr = 64'h3000;
      tick();
      burst(64'h3000, -1, -1, 0);
      chk("redir_new_hit", o_data_ready, 1);

      // Flush during refill
      i_addr = 64'h1000;
      tick();
      burst(64'h1000, 5, -1, 0);
      chk("flush_fill_rdy", o_data_ready, 0);
      chk("flush_miss_clr", o_miss_count, 0);
      tick();
      chk("flush_remiss", o_mem_req, 1);
`ifdef ICACHE_STATS_EN
      chk("miss_after_flush", o_miss_count, 1);
`else
      chk("miss_off", o_miss_count, 0);
`endif
      burst(64'h1000, -1, -1, 0);
      chk("post_flush_hit", o_data_ready, 1);
      tick(); tick(); tick();
`ifdef ICACHE_STATS_EN
      chk("hit_count", o_hit_count, 3);
`else
      chk("hit_off", o_hit_count, 0);
`endif

      // Stray acks in IDLE and flush suppressing a miss start
      i_mem_ack = 1'b1;
      tick();
      chk("stray_busy", o_busy, 0);
      chk("stray_rdy", o_data_ready, 1);
      i_mem_ack = 1'b0;
      i_addr = 64'h2000; i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      chk("flush_no_start", o_mem_req, 0);
      chk("flush_no_busy", o_busy, 0);

      // Reset in the middle of a burst
      tick();
      chk("rst_burst_req", o_mem_req, 1);
      for (int k = 0; k < 4; k++) begin
         i_mem_ack = 1'b1; i_mem_data = beat_data(k);
         tick();
      end
      i_reset_n = 1'b0;
      #1 chk("async_req", o_mem_req, 0);
      chk("async_busy", o_busy, 0);
      i_mem_ack = 1'b0;
      tick();
      i_reset_n = 1'b1;
      i_addr = 64'h1000;
      #1 chk("post_rst_miss", o_data_ready, 0);
      tick();
      burst(64'h1000, -1, -1, 0);
      chk("post_rst_hit", o_data_ready, 1);
      chk("post_rst_data", o_data, 32'h03020100);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
